// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latches six BCD digits on load, swaps them in at
// frame wrap, and scans them onto a 6-digit active-low 7-seg display.
// Params : SCAN_DIV (cycles per slot), BLANK_CYC (blank cycles per slot)
// Inputs : clk, rst_n (async, active-low), load, digit5..digit0
// Outputs: an[5:0] (active-low anodes), seg[6:0] {g..a} active-low,
//          frame_done (1-cycle pulse at frame wrap)
// Option : define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] digit5,
  input  logic [3:0] digit4,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLK  = DW'(BLANK_CYC);

  logic [DW-1:0]   div;
  logic [2:0]      idx;
  logic [5:0][3:0] disp;
  logic [5:0][3:0] pend;
  logic            pend_valid;

  logic       wrap;
  logic       fwrap;
  logic [3:0] cur;
  logic [5:0] onehot;
  logic [5:0] lz;
  logic       blank;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign wrap  = (div == LAST);
  assign fwrap = wrap && (idx == 3'd5);

  // lz[i]: digit i and everything above it are zero; digit 0 never blanks
  always_comb begin
    lz = '0;
`ifdef SEG7_LZB_EN
    lz[5] = (disp[5] == 4'd0);
    for (int i = 4; i >= 1; i--)
      lz[i] = lz[i+1] && (disp[i] == 4'd0);
`endif
  end

  always_comb begin
    cur    = disp[0];
    onehot = 6'b000001;
    case (idx)
      3'd1: begin cur = disp[1]; onehot = 6'b000010; end
      3'd2: begin cur = disp[2]; onehot = 6'b000100; end
      3'd3: begin cur = disp[3]; onehot = 6'b001000; end
      3'd4: begin cur = disp[4]; onehot = 6'b010000; end
      3'd5: begin cur = disp[5]; onehot = 6'b100000; end
      default: ;
    endcase
    blank = (div < BLK) || |(lz & onehot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      idx        <= '0;
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      an         <= 6'h3F;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      div        <= wrap ? '0 : div + 1'b1;
      frame_done <= fwrap;
      if (wrap)
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      if (fwrap && pend_valid) begin
        disp       <= pend;
        pend_valid <= 1'b0;
      end
      // a load on the wrap edge refills pending after the swap
      if (load) begin
        pend       <= {digit5, digit4, digit3,
                       digit2, digit1, digit0};
        pend_valid <= 1'b1;
      end
      if (blank) begin
        an  <= 6'h3F;
        seg <= 7'h7F;
      end else begin
        an  <= ~onehot;
        seg <= dec(cur);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver
// with SCAN_DIV=8, BLANK_CYC=2 (48-cycle frames).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [23:0] dval = '0;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  logic [5:0] fr_an[48];
  logic [6:0] fr_seg[48];
  logic       fr_fd[48];

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .digit5(dval[23:20]),
    .digit4(dval[19:16]),
    .digit3(dval[15:12]),
    .digit2(dval[11:8]),
    .digit1(dval[7:4]),
    .digit0(dval[3:0]),
    .an(an),
    .seg(seg),
    .frame_done(frame_done)
  );

  function automatic logic [6:0] tdec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic blk(input logic [23:0] v, input int s);
`ifdef SEG7_LZB_EN
    return (s != 0) && ((v >> (4 * s)) == 24'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [5:0] exp_an(input logic [23:0] v, input int j);
    int s = j / 8;
    if ((j % 8) < 2 || blk(v, s)) return 6'h3F;
    return 6'h3F ^ (6'd1 << s);
  endfunction

  function automatic logic [6:0] exp_seg(input logic [23:0] v, input int j);
    int s = j / 8;
    logic [23:0] t = v >> (4 * s);
    if ((j % 8) < 2 || blk(v, s)) return 7'h7F;
    return tdec(t[3:0]);
  endfunction

  // Captures one frame starting just after a wrap edge; optional loads
  // are presented before edge la / lb of the frame.
  task automatic capture_frame(input int la, input logic [23:0] va,
                               input int lb, input logic [23:0] vb);
    for (int j = 0; j < 48; j++) begin
      load = (j == la) || (j == lb);
      if (j == la) dval = va;
      if (j == lb) dval = vb;
      @(negedge clk);
      fr_an[j]  = an;
      fr_seg[j] = seg;
      fr_fd[j]  = frame_done;
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 6'h3F || seg !== 7'h7F || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals an=%h seg=%h fd=%b exp 3f 7f 0", an, seg, frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) break;
    end
    checks++;
    if (n != 48) begin
      failures++;
      $display("FAIL reset_first_fd cycles=%0d exp 48", n);
    end
    capture_frame(-1, 0, -1, 0);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(0, j) || fr_seg[j] !== exp_seg(0, j) || fr_fd[j] !== (j == 47)) begin
        failures++;
        $display("FAIL reset_frame j=%0d an=%h seg=%h fd=%b exp %h %h", j, fr_an[j], fr_seg[j], fr_fd[j], exp_an(0, j), exp_seg(0, j));
      end
    end
  endtask

  task automatic test_load_decode();
    capture_frame(20, 24'h123456, -1, 0);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(0, j) || fr_seg[j] !== exp_seg(0, j) || fr_fd[j] !== (j == 47)) begin
        failures++;
        $display("FAIL load_old j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(0, j), exp_seg(0, j));
      end
    end
    capture_frame(-1, 0, -1, 0);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(24'h123456, j) || fr_seg[j] !== exp_seg(24'h123456, j) || fr_fd[j] !== (j == 47)) begin
        failures++;
        $display("FAIL load_new j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(24'h123456, j), exp_seg(24'h123456, j));
      end
    end
    checks++;
    if (fr_an[2] !== 6'h3E || fr_seg[2] !== 7'h02) begin
      failures++;
      $display("FAIL slot0_decode an=%h seg=%h exp 3e 02", fr_an[2], fr_seg[2]);
    end
    checks++;
    if (fr_an[42] !== 6'h1F || fr_seg[42] !== 7'h79) begin
      failures++;
      $display("FAIL slot5_decode an=%h seg=%h exp 1f 79", fr_an[42], fr_seg[42]);
    end
  endtask

  task automatic test_double_load();
    capture_frame(5, 24'h111111, 30, 24'h999999);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(24'h123456, j) || fr_seg[j] !== exp_seg(24'h123456, j)) begin
        failures++;
        $display("FAIL dbl_old j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(24'h123456, j), exp_seg(24'h123456, j));
      end
    end
    capture_frame(-1, 0, -1, 0);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(24'h999999, j) || fr_seg[j] !== exp_seg(24'h999999, j) || fr_fd[j] !== (j == 47)) begin
        failures++;
        $display("FAIL dbl_new j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(24'h999999, j), exp_seg(24'h999999, j));
      end
    end
  endtask

  task automatic test_back_to_back();
    capture_frame(10, 24'h222222, 47, 24'h333333);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(24'h999999, j) || fr_seg[j] !== exp_seg(24'h999999, j)) begin
        failures++;
        $display("FAIL wrap_f0 j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(24'h999999, j), exp_seg(24'h999999, j));
      end
    end
    capture_frame(-1, 0, -1, 0);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(24'h222222, j) || fr_seg[j] !== exp_seg(24'h222222, j) || fr_fd[j] !== (j == 47)) begin
        failures++;
        $display("FAIL wrap_f1 j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(24'h222222, j), exp_seg(24'h222222, j));
      end
    end
    capture_frame(-1, 0, -1, 0);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(24'h333333, j) || fr_seg[j] !== exp_seg(24'h333333, j) || fr_fd[j] !== (j == 47)) begin
        failures++;
        $display("FAIL wrap_f2 j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(24'h333333, j), exp_seg(24'h333333, j));
      end
    end
  endtask

  task automatic test_invalid();
    capture_frame(10, 24'h00F00A, -1, 0);
    capture_frame(-1, 0, -1, 0);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(24'h00F00A, j) || fr_seg[j] !== exp_seg(24'h00F00A, j)) begin
        failures++;
        $display("FAIL invalid j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(24'h00F00A, j), exp_seg(24'h00F00A, j));
      end
    end
    checks++;
    if (fr_seg[2] !== 7'h3F || fr_seg[26] !== 7'h3F) begin
      failures++;
      $display("FAIL invalid_dash s0=%h s3=%h exp 3f 3f", fr_seg[2], fr_seg[26]);
    end
  endtask

  task automatic test_blanking();
    capture_frame(10, 24'h000042, -1, 0);
    capture_frame(-1, 0, 10, 24'h000000);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(24'h000042, j) || fr_seg[j] !== exp_seg(24'h000042, j)) begin
        failures++;
        $display("FAIL lzb_42 j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(24'h000042, j), exp_seg(24'h000042, j));
      end
    end
    checks++;
    if (fr_seg[10] !== 7'h19 || fr_seg[2] !== 7'h24) begin
      failures++;
      $display("FAIL lzb_digits s1=%h s0=%h exp 19 24", fr_seg[10], fr_seg[2]);
    end
    checks++;
`ifdef SEG7_LZB_EN
    if (fr_an[42] !== 6'h3F || fr_seg[42] !== 7'h7F) begin
      failures++;
      $display("FAIL lzb_slot5 an=%h seg=%h exp 3f 7f", fr_an[42], fr_seg[42]);
    end
`else
    if (fr_an[42] !== 6'h1F || fr_seg[42] !== 7'h40) begin
      failures++;
      $display("FAIL lzb_slot5 an=%h seg=%h exp 1f 40", fr_an[42], fr_seg[42]);
    end
`endif
    capture_frame(-1, 0, -1, 0);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(0, j) || fr_seg[j] !== exp_seg(0, j)) begin
        failures++;
        $display("FAIL lzb_0 j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(0, j), exp_seg(0, j));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (10) @(negedge clk);
    load = 1'b1;
    dval = 24'h777777;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 6'h3D) begin
      failures++;
      $display("FAIL mid_lit an=%h exp 3d", an);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 6'h3F || seg !== 7'h7F || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset an=%h seg=%h fd=%b exp 3f 7f 0", an, seg, frame_done);
    end
    @(negedge clk);
    load = 1'b1;
    dval = 24'h888888;
    repeat (2) @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) break;
    end
    checks++;
    if (n != 48) begin
      failures++;
      $display("FAIL mid_first_fd cycles=%0d exp 48", n);
    end
    capture_frame(-1, 0, -1, 0);
    for (int j = 0; j < 48; j++) begin
      checks++;
      if (fr_an[j] !== exp_an(0, j) || fr_seg[j] !== exp_seg(0, j) || fr_fd[j] !== (j == 47)) begin
        failures++;
        $display("FAIL mid_lost j=%0d an=%h seg=%h exp %h %h", j, fr_an[j], fr_seg[j], exp_an(0, j), exp_seg(0, j));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_decode();
    test_double_load();
    test_back_to_back();
    test_invalid();
    test_blanking();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
